sensor_sampler: RTL and testbench

//  Upstream front-end of the irrigation FSM. Periodically requests moisture and light

---
 rtl/irrigation_pkg.sv | 36 +++
 rtl/sensor_avg.sv | 42 ++++
 rtl/sensor_sampler.sv | 147 ++++++++++++++
 tb/tb_sensor_sampler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg : shared encodings for the irrigation sensor front-end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_M  = 2'd1,
    ST_REQ_L  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  localparam logic       CH_MOIST = 1'b0;
  localparam logic       CH_LIGHT = 1'b1;

  localparam logic [1:0] LT_NIGHT = 2'b00;
  localparam logic [1:0] LT_DUSK  = 2'b01;
  localparam logic [1:0] LT_DAY   = 2'b10;

  localparam logic [7:0] M_SAFE   = 8'd255;

  // Bright test first so inverted thresholds resolve to day.
  function automatic logic [1:0] light_class(input logic [7:0] light,
                                             input logic [7:0] dark_th,
                                             input logic [7:0] bright_th);
    if (light >= bright_th)    return LT_DAY;
    else if (light < dark_th)  return LT_NIGHT;
    else                       return LT_DUSK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_avg.sv
// ---------------------------------------------------------------------------
// sensor_avg : box-car moisture accumulator over 2**AVG_LOG2 samples
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sensor_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] avg
);

  localparam int c_AW = 8 + AVG_LOG2;
  localparam int c_CW = AVG_LOG2 + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(1 << AVG_LOG2);

  logic [c_AW-1:0] r_acc;
  logic [c_CW-1:0] r_cnt;

  // done holds until the owner clears; the accumulator never sees a sample past full.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (add) begin
      r_acc <= r_acc + c_AW'(din);
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign done = (r_cnt == c_FULL);
  assign avg  = 8'(r_acc >> AVG_LOG2);

endmodule

`default_nettype wire

// File: rtl/sensor_sampler.sv
// ---------------------------------------------------------------------------
// sensor_sampler : periodic ADC moisture/light sampling with safe fallback
// Rev 1.0   Option: LIGHT_HYST_EN (two-round agreement before l_thresh moves)
// ---------------------------------------------------------------------------
`default_nettype none

module sensor_sampler
  import irrigation_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [7:0]          l_dark_th,
  input  logic [7:0]          l_bright_th,
  output logic                adc_req,
  output logic                adc_ch,
  input  logic [7:0]          adc_data,
  input  logic                adc_ack,
  output logic [7:0]          m_sense,
  output logic [7:0]          l_sense,
  output logic [1:0]          l_thresh,
  output logic                sense_valid,
  output logic                timeout_err
);

  localparam int c_WW = $clog2(TIMEOUT + 1);
  localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(TIMEOUT - 1);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [c_WW-1:0]     r_wait_cnt;
`ifdef LIGHT_HYST_EN
  logic [1:0]          r_pend_cls;
  logic                r_pend_ok;
`endif

  logic       w_in_req;
  logic       w_timeout;
  logic       w_avg_add;
  logic       w_avg_clr;
  logic       w_avg_done;
  logic [7:0] w_avg;
  logic [1:0] w_cls;

  assign w_in_req  = (r_state == ST_REQ_M) || (r_state == ST_REQ_L);
  // An ack on the final wait cycle is taken as a result, not a timeout.
  assign w_timeout = w_in_req && adc_req && !adc_ack && (r_wait_cnt == c_WAIT_LAST);
  assign w_avg_add = (r_state == ST_REQ_M) && adc_req && adc_ack;
  assign w_avg_clr = w_timeout || ((r_state == ST_UPDATE) && w_avg_done);
  assign w_cls     = light_class(l_sense, l_dark_th, l_bright_th);

  sensor_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_avg_clr),
    .add  (w_avg_add),
    .din  (adc_data),
    .done (w_avg_done),
    .avg  (w_avg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_period_cnt <= '0;
      r_wait_cnt   <= '0;
      adc_req      <= 1'b0;
      adc_ch       <= CH_MOIST;
      m_sense      <= M_SAFE;
      l_sense      <= '0;
      l_thresh     <= LT_NIGHT;
      sense_valid  <= 1'b0;
      timeout_err  <= 1'b0;
`ifdef LIGHT_HYST_EN
      r_pend_cls   <= LT_NIGHT;
      r_pend_ok    <= 1'b0;
`endif
    end else begin
      sense_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_period_cnt == '0) begin
            r_state <= ST_REQ_M;
            adc_ch  <= CH_MOIST;
          end else begin
            r_period_cnt <= r_period_cnt - 1'b1;
          end
        end

        // First cycle in a request state raises adc_req, so req is low for a
        // cycle after every ack and acks are honoured only while req is high.
        ST_REQ_M, ST_REQ_L: begin
          if (!adc_req) begin
            adc_req    <= 1'b1;
            r_wait_cnt <= '0;
          end else if (adc_ack) begin
            adc_req <= 1'b0;
            if (r_state == ST_REQ_M) begin
              r_state <= ST_REQ_L;
              adc_ch  <= CH_LIGHT;
            end else begin
              l_sense <= adc_data;
              r_state <= ST_UPDATE;
            end
          end else if (w_timeout) begin
            adc_req      <= 1'b0;
            timeout_err  <= 1'b1;
            l_thresh     <= LT_NIGHT;
            r_state      <= ST_IDLE;
            r_period_cnt <= sample_period;
`ifdef LIGHT_HYST_EN
            r_pend_ok    <= 1'b0;
`endif
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_UPDATE: begin
`ifdef LIGHT_HYST_EN
          if (r_pend_ok && (w_cls == r_pend_cls))
            l_thresh <= w_cls;
          r_pend_cls <= w_cls;
          r_pend_ok  <= 1'b1;
`else
          l_thresh <= w_cls;
`endif
          if (w_avg_done)
            m_sense <= w_avg;
          sense_valid  <= 1'b1;
          timeout_err  <= 1'b0;
          r_state      <= ST_IDLE;
          r_period_cnt <= sample_period;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sensor_sampler.sv
// ---------------------------------------------------------------------------
// tb_sensor_sampler : directed vectors for sensor_sampler (default parameters)
// Rev 1.0   Option: LIGHT_HYST_EN
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sensor_sampler;
  import irrigation_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_period;
  logic [7:0]  l_dark_th, l_bright_th, adc_data;
  logic        adc_ack;
  logic        adc_req, adc_ch, sense_valid, timeout_err;
  logic [7:0]  m_sense, l_sense;
  logic [1:0]  l_thresh;

  sensor_sampler dut (
    .clk(clk), .rst_n(rst_n), .sample_period(sample_period),
    .l_dark_th(l_dark_th), .l_bright_th(l_bright_th),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_data(adc_data), .adc_ack(adc_ack),
    .m_sense(m_sense), .l_sense(l_sense), .l_thresh(l_thresh),
    .sense_valid(sense_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_sv = 0;
  always @(posedge clk) cyc++;

  logic [1:0] mdl_lt;
`ifdef LIGHT_HYST_EN
  logic [1:0] mdl_pend;
  logic       mdl_pend_ok;
`endif

  typedef struct {
    logic [7:0] moist;
    logic [7:0] light;
    logic [7:0] dark;
    logic [7:0] bright;
    logic [7:0] exp_m;
    logic [1:0] cls;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_lt = LT_NIGHT;
`ifdef LIGHT_HYST_EN
    mdl_pend_ok = 1'b0;
`endif
  endtask

  task automatic apply_class(input logic [1:0] c);
`ifdef LIGHT_HYST_EN
    if (mdl_pend_ok && c == mdl_pend) mdl_lt = c;
    mdl_pend    = c;
    mdl_pend_ok = 1'b1;
`else
    mdl_lt = c;
`endif
  endtask

  // Waits for adc_req, then returns a one-cycle ack dly cycles later.
  task automatic serve(input logic [7:0] data, input logic ch, input int dly, output int waited);
    waited = 0;
    while (adc_req !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("adc_req_seen", adc_req, 1);
    check("adc_ch", adc_ch, ch);
    repeat (dly) @(negedge clk);
    adc_data = data;
    adc_ack  = 1'b1;
    @(negedge clk);
    adc_ack  = 1'b0;
    adc_data = 8'd0;
  endtask

  task automatic do_round(input logic [7:0] m, input logic [7:0] l, input int dly,
                          input logic [7:0] exp_m, input logic [1:0] cls, input int exp_wait);
    int w;
    int sv;
    serve(m, CH_MOIST, dly, w);
    if (exp_wait >= 0) check("idle_gap", w, exp_wait);
    serve(l, CH_LIGHT, dly, w);
    sv = 0;
    while (sense_valid !== 1'b1 && sv < 8) begin
      @(negedge clk);
      sv++;
    end
    check("sense_valid_latency", sv, 1);
    apply_class(cls);
    check("m_sense", m_sense, exp_m);
    check("l_sense", l_sense, l);
    check("l_thresh", l_thresh, mdl_lt);
    check("timeout_err_clear", timeout_err, 0);
    last_sv = cyc;
  endtask

  initial begin
    int n;
    int prev_sv;
    bit saw_sv;

    tbl[0] = '{8'd100, 8'd20,  8'd50,  8'd150, 8'd255, LT_NIGHT};
    tbl[1] = '{8'd104, 8'd60,  8'd50,  8'd150, 8'd255, LT_DUSK};
    tbl[2] = '{8'd108, 8'd200, 8'd50,  8'd150, 8'd255, LT_DAY};
    tbl[3] = '{8'd112, 8'd150, 8'd50,  8'd150, 8'd106, LT_DAY};
    tbl[4] = '{8'd1,   8'd49,  8'd50,  8'd150, 8'd106, LT_NIGHT};
    tbl[5] = '{8'd2,   8'd50,  8'd50,  8'd150, 8'd106, LT_DUSK};
    tbl[6] = '{8'd3,   8'd149, 8'd50,  8'd150, 8'd106, LT_DUSK};
    tbl[7] = '{8'd5,   8'd255, 8'd50,  8'd150, 8'd2,   LT_DAY};
    tbl[8] = '{8'd7,   8'd150, 8'd200, 8'd100, 8'd2,   LT_DAY};

    rst_n = 1'b0; sample_period = 16'd4; l_dark_th = 8'd50; l_bright_th = 8'd150;
    adc_data = 8'd0; adc_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_m_sense", m_sense, 255);
    check("rst_l_sense", l_sense, 0);
    check("rst_l_thresh", l_thresh, 0);
    check("rst_adc_req", adc_req, 0);
    check("rst_adc_ch", adc_ch, 0);
    check("rst_sense_valid", sense_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;

    // Averaging, threshold classes and boundaries; ack 3 cycles after req.
    for (int i = 0; i < 9; i++) begin
      l_dark_th   = tbl[i].dark;
      l_bright_th = tbl[i].bright;
      do_round(tbl[i].moist, tbl[i].light, 3, tbl[i].exp_m, tbl[i].cls, (i == 0) ? -1 : 6);
    end

    // ADC never answers: req must fall after exactly 255 cycles.
    n = 0; saw_sv = 1'b0;
    while (adc_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (adc_req === 1'b1 && n < 300) begin
      if (sense_valid === 1'b1) saw_sv = 1'b1;
      @(negedge clk);
      n++;
    end
    check("timeout_req_cycles", n, 255);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_l_thresh", l_thresh, 0);
    check("timeout_m_held", m_sense, 2);
    check("timeout_l_held", l_sense, 150);
    check("timeout_no_valid", {31'd0, saw_sv | sense_valid}, 0);
    mdl_lt = LT_NIGHT;
`ifdef LIGHT_HYST_EN
    mdl_pend_ok = 1'b0;
`endif

    // Stray ack while idle must be ignored.
    adc_data = 8'd77; adc_ack = 1'b1;
    @(negedge clk);
    adc_ack = 1'b0; adc_data = 8'd0;

    // Ack on the last permitted wait cycle wins over the timeout.
    do_round(8'd255, 8'd150, 254, 8'd2, LT_DAY, -1);

    // Back-to-back rounds, immediate ack, full-scale moisture.
    sample_period = 16'd0; l_dark_th = 8'd50; l_bright_th = 8'd150;
    do_round(8'd255, 8'd100, 0, 8'd2, LT_DUSK, -1);
    prev_sv = last_sv;
    do_round(8'd255, 8'd100, 0, 8'd2, LT_DUSK, 2);
    check("b2b_period", last_sv - prev_sv, 6);
    prev_sv = last_sv;
    do_round(8'd255, 8'd100, 0, 8'd255, LT_DUSK, 2);
    check("b2b_period2", last_sv - prev_sv, 6);

    // Reset while waiting on the light conversion.
    sample_period = 16'd2;
    serve(8'd99, CH_MOIST, 1, n);
    n = 0;
    while (adc_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("reql_reached", adc_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_m_sense", m_sense, 255);
    check("mid_rst_l_sense", l_sense, 0);
    check("mid_rst_l_thresh", l_thresh, 0);
    check("mid_rst_adc_req", adc_req, 0);
    check("mid_rst_adc_ch", adc_ch, 0);
    check("mid_rst_sense_valid", sense_valid, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    model_reset();
    do_round(8'd10, 8'd60, 1, 8'd255, LT_DUSK, -1);
    do_round(8'd20, 8'd60, 1, 8'd255, LT_DUSK, 4);
    do_round(8'd30, 8'd60, 1, 8'd255, LT_DUSK, 4);
    do_round(8'd40, 8'd60, 1, 8'd25,  LT_DUSK, 4);

`ifdef LIGHT_HYST_EN
    // Alternating classes never commit; two agreeing rounds do.
    do_round(8'd0, 8'd200, 1, 8'd25, LT_DAY, 4);
    check("hyst_alt1", l_thresh, LT_DUSK);
    do_round(8'd0, 8'd60, 1, 8'd25, LT_DUSK, 4);
    check("hyst_alt2", l_thresh, LT_DUSK);
    do_round(8'd0, 8'd200, 1, 8'd25, LT_DAY, 4);
    check("hyst_alt3", l_thresh, LT_DUSK);
    do_round(8'd0, 8'd200, 1, 8'd0, LT_DAY, 4);
    check("hyst_commit", l_thresh, LT_DAY);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
